// File: rtl/global_pkg.sv
// Shared DMA definitions: controller state encoding and the buffer layout
// that the CPU memory map also relies on.
package global_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX_REQ,
    RX_WR,
    TX_REQ,
    TX_RD,
    TX_LAT,
    TX_SEND
  } dma_state_t;

  localparam logic [7:0]  DMA_RX_BASE = 8'h00;
  localparam logic [7:0]  DMA_TX_BASE = 8'h04;
  localparam int unsigned DMA_RX_LEN  = 3;
  localparam int unsigned DMA_TX_LEN  = 2;

  // Buffer addressing is plain 8-bit arithmetic; overflow wraps silently.
  function automatic logic [7:0] buf_addr(input logic [7:0] base,
                                          input logic [7:0] offset);
    return base + offset;
  endfunction

endpackage

// File: rtl/dma_controller.sv
// UART <-> RAM DMA engine: drains the RX FIFO into a circular RAM buffer and
// streams a fixed-length RAM buffer to the transmitter, borrowing the CPU bus.
module dma_controller
  import global_pkg::*;
#(
  parameter logic [7:0]  RX_BUF_BASE = DMA_RX_BASE,
  parameter int unsigned RX_BUF_LEN  = DMA_RX_LEN,
  parameter logic [7:0]  TX_BUF_BASE = DMA_TX_BASE,
  parameter int unsigned TX_LEN      = DMA_TX_LEN
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [7:0] RX_Data,
  input  logic       RX_Empty,
  output logic       Data_Read,
  output logic [7:0] TX_Data,
  output logic       Valid_D,
  input  logic       Ack_out,
  input  logic       Dma_Tx_Start,
  output logic       Ready,
  output logic       Bus_Req,
  input  logic       Bus_Grant,
  output logic [7:0] Mem_Addr,
  output logic [7:0] Mem_Data_Out,
  input  logic [7:0] Mem_Data_In,
  output logic       Mem_CS,
  output logic       Mem_WE,
  output logic       Mem_OE
);

  localparam logic [7:0] RX_LAST = 8'(RX_BUF_LEN - 1);
  localparam logic [7:0] TX_LAST = 8'(TX_LEN - 1);

  dma_state_t state;
  logic [7:0] rx_ptr;
  logic [7:0] tx_cnt;
  logic       tx_pend;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= IDLE;
      rx_ptr       <= '0;
      tx_cnt       <= '0;
      tx_pend      <= 1'b0;
      Ready        <= 1'b1;
      Data_Read    <= 1'b0;
      TX_Data      <= '0;
      Valid_D      <= 1'b0;
      Bus_Req      <= 1'b0;
      Mem_Addr     <= '0;
      Mem_Data_Out <= '0;
      Mem_CS       <= 1'b0;
      Mem_WE       <= 1'b0;
      Mem_OE       <= 1'b0;
    end else begin
      // Memory strobes and the FIFO pop live for exactly one access cycle.
      Data_Read    <= 1'b0;
      Mem_Addr     <= '0;
      Mem_Data_Out <= '0;
      Mem_CS       <= 1'b0;
      Mem_WE       <= 1'b0;
      Mem_OE       <= 1'b0;

      if (Dma_Tx_Start && Ready) begin
        tx_pend <= 1'b1;
        Ready   <= 1'b0;
      end

      case (state)
        IDLE: begin
          // RX wins so the UART FIFO cannot overflow behind a long TX job.
          if (!RX_Empty) begin
            state   <= RX_REQ;
            Bus_Req <= 1'b1;
          end else if (tx_pend) begin
            state   <= TX_REQ;
            Bus_Req <= 1'b1;
          end
        end

        RX_REQ: begin
          if (Bus_Grant) begin
            state        <= RX_WR;
            Mem_CS       <= 1'b1;
            Mem_WE       <= 1'b1;
            Mem_Addr     <= buf_addr(RX_BUF_BASE, rx_ptr);
            Mem_Data_Out <= RX_Data;
            Data_Read    <= 1'b1;
          end
        end

        RX_WR: begin
          state   <= IDLE;
          Bus_Req <= 1'b0;
          rx_ptr  <= (rx_ptr == RX_LAST) ? '0 : rx_ptr + 8'd1;
        end

        TX_REQ: begin
          if (Bus_Grant) begin
            state    <= TX_RD;
            Mem_CS   <= 1'b1;
            Mem_OE   <= 1'b1;
            Mem_Addr <= buf_addr(TX_BUF_BASE, tx_cnt);
          end
        end

        TX_RD: begin
          state   <= TX_LAT;
          Bus_Req <= 1'b0;
        end

        TX_LAT: begin
          state   <= TX_SEND;
          TX_Data <= Mem_Data_In;
          Valid_D <= 1'b1;
        end

        TX_SEND: begin
          if (Ack_out) begin
            Valid_D <= 1'b0;
            state   <= IDLE;
            if (tx_cnt == TX_LAST) begin
              tx_cnt  <= '0;
              tx_pend <= 1'b0;
              Ready   <= 1'b1;
            end else begin
              tx_cnt <= tx_cnt + 8'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller with a behavioural RX FIFO, synchronous
// RAM and a bus arbiter that either follows Bus_Req or is forced.
module tb_dma_controller;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic [7:0] RX_Data;
  logic       RX_Empty;
  logic       Data_Read;
  logic [7:0] TX_Data;
  logic       Valid_D;
  logic       Ack_out = 1'b0;
  logic       Dma_Tx_Start = 1'b0;
  logic       Ready;
  logic       Bus_Req;
  logic       Bus_Grant;
  logic [7:0] Mem_Addr;
  logic [7:0] Mem_Data_Out;
  logic [7:0] Mem_Data_In;
  logic       Mem_CS;
  logic       Mem_WE;
  logic       Mem_OE;

  logic       grant_tie = 1'b1;
  logic       grant_force = 1'b0;

  logic [7:0]  fifo_mem [16];
  int unsigned wr_idx = 0;
  int unsigned rd_idx = 0;

  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] ram_q = 8'h00;
  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = 8'h00;
  logic [7:0] pre_data = 8'h00;

  int n_checks = 0;
  int n_fail = 0;
  int unsigned base;
  int bad;

  always #5 Clk = ~Clk;

  assign RX_Empty    = (wr_idx == rd_idx);
  assign RX_Data     = fifo_mem[rd_idx % 16];
  assign Bus_Grant   = grant_tie ? Bus_Req : grant_force;
  assign Mem_Data_In = ram_q;

  always @(posedge Clk) if (Data_Read) rd_idx <= rd_idx + 1;

  always @(posedge Clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (Mem_CS && Bus_Grant) begin
      if (Mem_WE) mem[Mem_Addr] <= Mem_Data_Out;
      if (Mem_OE) ram_q <= mem[Mem_Addr];
    end
  end

  dma_controller #(
    .RX_BUF_BASE(8'h00),
    .RX_BUF_LEN (3),
    .TX_BUF_BASE(8'h04),
    .TX_LEN     (2)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .RX_Data     (RX_Data),
    .RX_Empty    (RX_Empty),
    .Data_Read   (Data_Read),
    .TX_Data     (TX_Data),
    .Valid_D     (Valid_D),
    .Ack_out     (Ack_out),
    .Dma_Tx_Start(Dma_Tx_Start),
    .Ready       (Ready),
    .Bus_Req     (Bus_Req),
    .Bus_Grant   (Bus_Grant),
    .Mem_Addr    (Mem_Addr),
    .Mem_Data_Out(Mem_Data_Out),
    .Mem_Data_In (Mem_Data_In),
    .Mem_CS      (Mem_CS),
    .Mem_WE      (Mem_WE),
    .Mem_OE      (Mem_OE)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_idx % 16] = b;
    wr_idx++;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge Clk);
    pre_we = 1'b0;
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic start_pulse();
    Dma_Tx_Start = 1'b1;
    @(negedge Clk);
    Dma_Tx_Start = 1'b0;
  endtask

  task automatic ack();
    Ack_out = 1'b1;
    @(negedge Clk);
    Ack_out = 1'b0;
  endtask

  task automatic wait_valid(input int unsigned max);
    for (int unsigned i = 0; i < max && !Valid_D; i++) @(negedge Clk);
  endtask

  task automatic wait_cs(input int unsigned max);
    for (int unsigned i = 0; i < max && !Mem_CS; i++) @(negedge Clk);
  endtask

  initial begin
    // Reset state and a quiet idle period
    cycles(2);
    #1;
    check("rst_ready", Ready, 1'b1);
    check("rst_busreq", Bus_Req, 1'b0);
    check("rst_valid", Valid_D, 1'b0);
    check("rst_txdata", TX_Data, 8'h00);
    check("rst_mem", {Mem_CS, Mem_WE, Mem_OE, Data_Read}, 4'b0000);
    @(negedge Clk);
    Rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (!Ready || Bus_Req || Mem_CS || Mem_WE || Mem_OE || Data_Read ||
          Mem_Addr != 8'h00 || Mem_Data_Out != 8'h00) bad++;
    end
    check("idle_quiet", bad, 0);

    // Four RX bytes into a three-entry circular buffer
    base = rd_idx;
    push(8'hAB); push(8'hCD); push(8'hEF); push(8'h12);
    @(negedge Clk);
    check("rx_req", {Bus_Req, Mem_CS}, 2'b10);
    @(negedge Clk);
    check("rx_wr_strobes", {Mem_CS, Mem_WE, Mem_OE, Data_Read}, 4'b1101);
    check("rx_wr_addr", Mem_Addr, 8'h00);
    check("rx_wr_data", Mem_Data_Out, 8'hAB);
    cycles(15);
    check("rx_ram0_wrap", mem[0], 8'h12);
    check("rx_ram1", mem[1], 8'hCD);
    check("rx_ram2", mem[2], 8'hEF);
    check("rx_ram3_untouched", mem[3], 8'h00);
    check("rx_pops", rd_idx - base, 4);
    check("rx_done_busreq", Bus_Req, 1'b0);

    // TX job of two bytes
    preload(8'h04, 8'h55);
    preload(8'h05, 8'hAA);
    start_pulse();
    check("tx_ready_drop", Ready, 1'b0);
    @(negedge Clk);
    check("tx_req", {Bus_Req, Mem_CS}, 2'b10);
    @(negedge Clk);
    check("tx_rd_strobes", {Mem_CS, Mem_WE, Mem_OE}, 3'b101);
    check("tx_rd_addr", Mem_Addr, 8'h04);
    @(negedge Clk);
    check("tx_lat", {Mem_CS, Valid_D}, 2'b00);
    @(negedge Clk);
    check("tx_valid_lat5", Valid_D, 1'b1);
    check("tx_byte0", TX_Data, 8'h55);
    check("tx_send_busreq", Bus_Req, 1'b0);
    start_pulse();
    cycles(2);
    check("tx_hold_valid", Valid_D, 1'b1);
    check("tx_hold_data", TX_Data, 8'h55);
    ack();
    check("tx_ack0_valid", Valid_D, 1'b0);
    check("tx_ack0_ready", Ready, 1'b0);
    wait_valid(20);
    check("tx_valid1", Valid_D, 1'b1);
    check("tx_byte1", TX_Data, 8'hAA);
    ack();
    check("tx_ack1_valid", Valid_D, 1'b0);
    check("tx_done_ready", Ready, 1'b1);
    ack();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (Bus_Req || Valid_D || !Ready) bad++;
    end
    check("tx_no_rerun", bad, 0);

    // Grant withheld for 50 cycles
    grant_tie = 1'b0;
    grant_force = 1'b0;
    push(8'h77);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (Mem_CS || Data_Read) bad++;
    end
    check("nogrant_quiet", bad, 0);
    check("nogrant_req", Bus_Req, 1'b1);
    grant_force = 1'b1;
    @(negedge Clk);
    check("grant_wr_strobes", {Mem_CS, Mem_WE, Data_Read}, 3'b111);
    check("grant_wr_addr", Mem_Addr, 8'h01);
    check("grant_wr_data", Mem_Data_Out, 8'h77);
    @(negedge Clk);
    grant_tie = 1'b1;
    grant_force = 1'b0;
    check("grant_release", Bus_Req, 1'b0);
    cycles(2);
    check("grant_ram1", mem[1], 8'h77);

    // RX byte interleaved between TX bytes
    start_pulse();
    wait_valid(20);
    check("mix_valid0", Valid_D, 1'b1);
    check("mix_byte0", TX_Data, 8'h55);
    push(8'h3C);
    cycles(2);
    ack();
    wait_cs(10);
    check("mix_rx_first", {Mem_CS, Mem_WE, Mem_OE}, 3'b110);
    check("mix_rx_addr", Mem_Addr, 8'h02);
    check("mix_rx_data", Mem_Data_Out, 8'h3C);
    wait_valid(20);
    check("mix_valid1", Valid_D, 1'b1);
    check("mix_byte1", TX_Data, 8'hAA);
    ack();
    check("mix_ready", Ready, 1'b1);
    check("mix_ram2", mem[2], 8'h3C);

    // Reset in the middle of TX_SEND
    start_pulse();
    wait_valid(20);
    check("rst_mid_valid", Valid_D, 1'b1);
    #2 Rst_n = 1'b0;
    #1;
    check("rst_mid_valid_low", Valid_D, 1'b0);
    check("rst_mid_ready", Ready, 1'b1);
    check("rst_mid_busreq", Bus_Req, 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1;
    push(8'h99);
    cycles(2);
    check("rst_rxptr_cs", Mem_CS, 1'b1);
    check("rst_rxptr_addr", Mem_Addr, 8'h00);
    cycles(2);
    start_pulse();
    wait_valid(20);
    check("rst_resend_byte0", TX_Data, 8'h55);
    ack();
    wait_valid(20);
    check("rst_resend_byte1", TX_Data, 8'hAA);
    ack();
    check("rst_resend_ready", Ready, 1'b1);
    check("rst_ram0", mem[0], 8'h99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
